// File: rtl/fwrisc_uart_loader.sv
// UART program loader: packs received bytes little-endian into 32-bit words,
// writes them to instruction RAM and holds the core in reset until the image is complete.
module fwrisc_uart_loader #(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              program_receiving,
  output logic              program_done,
  output logic              program_ov
);

  localparam int BCNT_W = $clog2(MEM_BYTES);
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(MEM_BYTES - 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FINISH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [BCNT_W-1:0]   bcnt_r, bcnt_s;
  logic [23:0]         pack_r, pack_s;
  logic                mem_we_r, mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic [31:0]         mem_wdata_r, mem_wdata_s;
  logic                core_reset_r, core_reset_s;
  logic                recv_r, recv_s;
  logic                done_r, done_s;
  logic                ov_r, ov_s;

  // Next-state and next-output logic; restart overrides every state and drops a coincident byte
  always_comb begin
    state_s      = state_r;
    bcnt_s       = bcnt_r;
    pack_s       = pack_r;
    mem_we_s     = 1'b0;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    core_reset_s = core_reset_r;
    recv_s       = 1'b0;
    done_s       = done_r;
    ov_s         = ov_r;

    if (restart) begin
      state_s      = ST_LOAD;
      bcnt_s       = '0;
      pack_s       = 24'h00_0000;
      done_s       = 1'b0;
      ov_s         = 1'b0;
      core_reset_s = 1'b1;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (rx_valid) begin
            recv_s = 1'b1;
            bcnt_s = bcnt_r + BCNT_ONE;
            // Lanes 0..2 are staged; lane 3 completes the word and issues the write
            case (bcnt_r[1:0])
              2'd0: pack_s[7:0]   = rx_data;
              2'd1: pack_s[15:8]  = rx_data;
              2'd2: pack_s[23:16] = rx_data;
              2'd3: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = bcnt_r[BCNT_W-1:2];
                mem_wdata_s = {rx_data, pack_r};
              end
              default: pack_s = pack_r;
            endcase
            if (bcnt_r == LAST_IDX) begin
              state_s = ST_FINISH;
            end else begin
              state_s = ST_LOAD;
            end
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_FINISH: begin
          state_s      = ST_DONE;
          done_s       = 1'b1;
          core_reset_s = 1'b0;
          if (rx_valid) begin
            ov_s = 1'b1;
          end else begin
            ov_s = ov_r;
          end
        end
        ST_DONE: begin
          if (rx_valid) begin
            ov_s = 1'b1;
          end else begin
            ov_s = ov_r;
          end
        end
        default: begin
          state_s = ST_LOAD;
        end
      endcase
    end
  end

  // State and registered-output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_LOAD;
      bcnt_r       <= '0;
      pack_r       <= 24'h00_0000;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 32'h0000_0000;
      core_reset_r <= 1'b1;
      recv_r       <= 1'b0;
      done_r       <= 1'b0;
      ov_r         <= 1'b0;
    end else begin
      state_r      <= state_s;
      bcnt_r       <= bcnt_s;
      pack_r       <= pack_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      core_reset_r <= core_reset_s;
      recv_r       <= recv_s;
      done_r       <= done_s;
      ov_r         <= ov_s;
    end
  end

  assign mem_we            = mem_we_r;
  assign mem_addr          = mem_addr_r;
  assign mem_wdata         = mem_wdata_r;
  assign core_reset        = core_reset_r;
  assign program_receiving = recv_r;
  assign program_done      = done_r;
  assign program_ov        = ov_r;

endmodule

// File: tb/tb_fwrisc_uart_loader.sv
// Scoreboard bench for fwrisc_uart_loader: expected writes are queued by the stimulus
// and consumed by a monitor that watches mem_we / program_receiving.
module tb_fwrisc_uart_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        restart;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        program_receiving;
  logic        program_done;
  logic        program_ov;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          ack_cnt = 0;
  int          ack_base;
  logic [9:0]  last_addr = 10'h000;
  logic [31:0] last_data = 32'h0;

  always #5 clk = ~clk;

  fwrisc_uart_loader #(.MEM_BYTES(4096), .ADDR_W(10)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .restart           (restart),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .core_reset        (core_reset),
    .program_receiving (program_receiving),
    .program_done      (program_done),
    .program_ov        (program_ov)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts acks and matches every RAM write against the scoreboard queue
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (program_receiving) ack_cnt++;
      if (mem_we) begin
        check("we_with_ack", {31'd0, program_receiving}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, expected no write", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", {22'd0, mem_addr}, {22'd0, mon_e.addr});
          check("wr_data", mem_wdata, mon_e.data);
        end
        last_addr = mem_addr;
        last_data = mem_wdata;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic done, input logic ov, input logic crst);
    check({tag, "_done"}, {31'd0, program_done}, {31'd0, done});
    check({tag, "_ov"}, {31'd0, program_ov}, {31'd0, ov});
    check({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, crst});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] b0, b1, b2, b3;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    restart  = 1'b0;

    // Reset state, then unchanged after release with no traffic
    settle(3);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_ack", {31'd0, program_receiving}, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    settle(5);
    check("idle_we", {31'd0, mem_we}, 32'd0);
    check("idle_ack", {31'd0, program_receiving}, 32'd0);
    check_status("idle", 1'b0, 1'b0, 1'b1);

    // Single word, one byte every 100 cycles
    ack_base = ack_cnt;
    exp_q.push_back('{addr: 10'h000, data: 32'h0000_0513});
    send_byte(8'h13); settle(99);
    send_byte(8'h05); settle(99);
    send_byte(8'h00); settle(99);
    send_byte(8'h00); settle(3);
    check("single_acks", ack_cnt - ack_base, 32'd4);
    check("single_last_data", last_data, 32'h0000_0513);
    check_status("single", 1'b0, 1'b0, 1'b1);

    // Full image paced on ack, byte i = i[7:0]
    pulse_restart();
    ack_base = ack_cnt;
    for (int w = 0; w < 1024; w++) begin
      b0 = 8'(4 * w);
      b1 = 8'(4 * w + 1);
      b2 = 8'(4 * w + 2);
      b3 = 8'(4 * w + 3);
      exp_q.push_back('{addr: 10'(w), data: {b3, b2, b1, b0}});
    end
    for (int i = 0; i < 4096; i++) begin
      send_byte(8'(i));
      k = 0;
      while (!program_receiving && k < 8) begin
        @(negedge clk);
        k++;
      end
      if (k == 8) check("pace_ack_timeout", 32'd0, 32'd1);
    end
    check_status("last_plus1", 1'b0, 1'b0, 1'b1);
    settle(1);
    check_status("last_plus2", 1'b1, 1'b0, 1'b0);
    check("image_acks", ack_cnt - ack_base, 32'd4096);
    check("image_last_addr", {22'd0, last_addr}, 32'h0000_03FF);
    check("image_last_data", last_data, 32'hFFFE_FDFC);
    check("image_pending", exp_q.size(), 32'd0);

    // Overflow after done: sticky, no ack, no write
    ack_base = ack_cnt;
    send_byte(8'hAA);
    check_status("ov_rise", 1'b1, 1'b1, 1'b0);
    settle(4);
    check_status("ov_sticky", 1'b1, 1'b1, 1'b0);
    check("ov_acks", ack_cnt - ack_base, 32'd0);
    pulse_restart();
    check_status("ov_restart", 1'b0, 1'b0, 1'b1);

    // Restart mid-word drops the partial second word
    ack_base = ack_cnt;
    exp_q.push_back('{addr: 10'h000, data: 32'hA3A2_A1A0});
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    pulse_restart();
    exp_q.push_back('{addr: 10'h000, data: 32'h4433_2211});
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    settle(3);
    check("midword_acks", ack_cnt - ack_base, 32'd10);
    check("midword_last_data", last_data, 32'h4433_2211);
    check_status("midword", 1'b0, 1'b0, 1'b1);

    // Restart coincident with a byte, then 8 back-to-back bytes from address 0
    pulse_restart();
    ack_base = ack_cnt;
    @(negedge clk);
    restart  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(negedge clk);
    restart  = 1'b0;
    rx_valid = 1'b0;
    settle(2);
    check("simul_acks", ack_cnt - ack_base, 32'd0);
    ack_base = ack_cnt;
    exp_q.push_back('{addr: 10'h000, data: 32'h0403_0201});
    exp_q.push_back('{addr: 10'h001, data: 32'h0807_0605});
    @(negedge clk);
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(i + 1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    settle(3);
    check("b2b_acks", ack_cnt - ack_base, 32'd8);
    check("b2b_last_addr", {22'd0, last_addr}, 32'h0000_0001);
    check("b2b_last_data", last_data, 32'h0807_0605);
    check("final_pending", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwrisc_uart_loader.md
# fwrisc_uart_loader

Program loader behind the UART receiver inside `fwrisc_fpga_top`. It consumes received bytes, packs each group of four into a little-endian 32-bit word and writes that word into the instruction RAM. It holds the fwrisc core in reset until the image is complete. It drives the host-visible `program_receiving` / `program_done` / `program_ov` status lines that pace the host-side sender.

## Interface
- `MEM_BYTES`, default 4096: image length in bytes; must be a multiple of 4.
- `ADDR_W`, default 10: word-address width; equals log2(`MEM_BYTES`/4).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `rx_data`  in  8  received byte, valid only while `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte; may assert on consecutive cycles.
- `restart`  in  1  sync one-cycle pulse; re-arms the loader.
- `mem_we`  out  1  one-cycle RAM write strobe.
- `mem_addr`  out  `ADDR_W`  RAM word address.
- `mem_wdata`  out  32  RAM write data.
- `core_reset`  out  1  active-high reset to the fwrisc core.
- `program_receiving`  out  1  one-cycle ack pulse per accepted byte.
- `program_done`  out  1  level; image complete.
- `program_ov`  out  1  sticky; a byte arrived after completion.

## Operation
- State machine states: LOAD, FINISH, DONE.
- LOAD: every `rx_valid` byte is accepted.
  - Byte counter `bcnt` (log2(`MEM_BYTES`) bits) increments.
  - Byte lane `bcnt[1:0]` selects the packing position: lane 0 goes to `wdata[7:0]`, lane 3 goes to `wdata[31:24]`.
  - When lane 3 is accepted, the assembled word is written to address `bcnt[msb:2]`.
  - The packing register is not cleared between words; each word is fully overwritten.
- LOAD→FINISH: on acceptance of byte index `MEM_BYTES`-1.
- FINISH→DONE: unconditionally on the next cycle.
- DONE:
  - `rx_valid` sets `program_ov`.
  - The byte is discarded: no `mem_we`, no `program_receiving` pulse.
  - DONE persists until `restart`.
- `restart`, in any state:
  - next state is LOAD;
  - `bcnt` is cleared to 0;
  - `program_done`, `program_ov` and the packing register are cleared;
  - `core_reset` is set to 1.
- Partially received words at `restart` are discarded; no write is issued for them.
- `restart` and `rx_valid` in the same cycle: `restart` wins and the byte is dropped (no ack).
- A byte arriving in FINISH is accepted as overflow: it sets `program_ov`, with no write.
- `bcnt` wraps naturally. Wrap is unreachable in LOAD because the transition to FINISH happens first.

## Timing
- All outputs are registered.
- Reset values:
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `core_reset`=1;
  - `program_receiving`=0, `program_done`=0, `program_ov`=0;
  - state LOAD, `bcnt`=0.
- Byte accepted at edge N (`rx_valid` sampled high):
  - `program_receiving`=1 for the cycle after edge N, exactly one cycle;
  - for lane 3, `mem_we`=1 in that same cycle, with `mem_addr`/`mem_wdata` stable alongside it.
- Throughput: one byte per cycle sustained, no back-pressure. Back-to-back lane-3 bytes cannot occur.
- Final byte accepted at edge N:
  - last `mem_we` is in cycle N+1;
  - `program_done`=1 and `core_reset`=0 from cycle N+2 onward.
- `program_ov` rises in the cycle after the offending `rx_valid`.
- `restart` sampled at edge R:
  - `core_reset`=1 from cycle R+1;
  - `program_done`=0 and `program_ov`=0 from cycle R+1;
  - a `mem_we` scheduled for cycle R+1 is suppressed.
- Asynchronous reset mid-load: all state returns to reset values immediately. No partial write is emitted after `rst_n` deasserts.

## Test plan
- Reset check: hold `rst_n`=0 → `core_reset`=1, all other outputs 0. Release `rst_n` → outputs unchanged until the first `rx_valid`.
- Single word: send bytes 0x13, 0x05, 0x00, 0x00, one every 100 cycles →
  - four `program_receiving` pulses;
  - one `mem_we` with `mem_addr`=0, `mem_wdata`=0x00000513, coincident with the 4th ack;
  - `program_done` stays 0.
- Full image: send 4096 bytes paced on the rising edge of `program_receiving`, with byte i = i[7:0] →
  - 1024 writes;
  - last write `mem_addr`=0x3FF, `mem_wdata`=0xFFFEFDFC;
  - `program_done`=1 and `core_reset`=0 two cycles after the last accepted byte.
- Overflow: after done, send 0xAA → `program_ov`=1 and sticky, no `mem_we`, no ack. Then pulse `restart` → `program_ov`=0, `program_done`=0, `core_reset`=1.
- Restart mid-word: send 6 bytes, then `restart`, then 4 bytes 0x11, 0x22, 0x33, 0x44 → writes at addr 0 (first image) and a later write at addr 0 with 0x44332211. No write at addr 1.
- Simultaneous restart and byte; back-to-back bytes:
  - `restart` in the same cycle as `rx_valid` → no ack, `bcnt` stays 0;
  - 8 consecutive-cycle `rx_valid` → 8 acks, 2 writes at addr 0 and 1.
